gray_bin_stream_conv: RTL and testbench

- Parametrised, pipelined successor to the team's combinational Gray-to-binary converter.
- Converts a valid/ready stream of WIDTH-bit words. A mode bit travels with each beat and selects Gray-to-binary (G2B) or binary-to-Gray (B2G).
- Adds a Gray step checker for G2B beats, used to debug CDC pointers, and a beat counter.
- Sits between a pointer/sample source and downstream consumers (UART TX data path, FIFO status logic).

---
 rtl/gray_bin_stream_conv.sv | 124 ++++++++++++
 tb/tb_gray_bin_stream_conv.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_stream_conv.sv
// Two-stage valid/ready stream converter between Gray and binary code, with a
// Gray step checker on G2B beats and a count of beats delivered downstream.
module gray_bin_stream_conv #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_mode,
   output logic                 out_step_err,
   output logic [CNT_WIDTH-1:0] beat_cnt
);

   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_data_q, s1_data_d;
   logic                 s1_mode_q, s1_mode_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic                 out_mode_q, out_mode_d;
   logic                 out_step_err_q, out_step_err_d;
   logic [WIDTH-1:0]     last_gray_q, last_gray_d;
   logic                 hist_valid_q, hist_valid_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

   logic                 s2_adv;
   logic                 s1_adv;
   logic [WIDTH-1:0]     g2b;
   logic [WIDTH-1:0]     b2g;
   logic [WIDTH-1:0]     gray_diff;
   logic                 step_err;

   // Binary bit i is the XOR of all Gray bits from i up to the MSB.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign g2b[gi] = ^s1_data_q[WIDTH-1:gi];
   end

   assign b2g       = s1_data_q ^ (s1_data_q >> 1);
   assign gray_diff = s1_data_q ^ last_gray_q;
   // More than one bit set <=> clearing the lowest set bit leaves something.
   assign step_err  = hist_valid_q & ~s1_mode_q & (|(gray_diff & (gray_diff - WIDTH'(1))));

   assign s2_adv   = ~out_valid_q | out_ready;
   assign s1_adv   = s1_valid_q & s2_adv;
   assign in_ready = rst_n & (~s1_valid_q | s2_adv);

   always_comb begin
      s1_valid_d     = s1_valid_q;
      s1_data_d      = s1_data_q;
      s1_mode_d      = s1_mode_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_mode_d     = out_mode_q;
      out_step_err_d = out_step_err_q;
      last_gray_d    = last_gray_q;
      hist_valid_d   = hist_valid_q;
      beat_cnt_d     = beat_cnt_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_mode_d = in_mode;
         end
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
      end

      if (s1_adv) begin
         out_data_d     = s1_mode_q ? b2g : g2b;
         out_mode_d     = s1_mode_q;
         out_step_err_d = step_err;
         if (!s1_mode_q) begin
            last_gray_d  = s1_data_q;
            hist_valid_d = 1'b1;
         end
      end

      if (out_valid_q && out_ready) begin
         beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_data_q      <= '0;
         s1_mode_q      <= 1'b0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_mode_q     <= 1'b0;
         out_step_err_q <= 1'b0;
         last_gray_q    <= '0;
         hist_valid_q   <= 1'b0;
         beat_cnt_q     <= '0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_data_q      <= s1_data_d;
         s1_mode_q      <= s1_mode_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_mode_q     <= out_mode_d;
         out_step_err_q <= out_step_err_d;
         last_gray_q    <= last_gray_d;
         hist_valid_q   <= hist_valid_d;
         beat_cnt_q     <= beat_cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_mode     = out_mode_q;
   assign out_step_err = out_step_err_q;
   assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_gray_bin_stream_conv.sv
// Directed bench for gray_bin_stream_conv: hand-computed vectors plus an
// in-order scoreboard of expected beats.
module tb_gray_bin_stream_conv;

   localparam int W  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_mode;
   logic          out_step_err;
   logic [CW-1:0] beat_cnt;

   always #5 clk = ~clk;

   gray_bin_stream_conv #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_mode      (in_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_mode     (out_mode),
      .out_step_err (out_step_err),
      .beat_cnt     (beat_cnt)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         m;
      logic         e;
   } beat_t;

   int            n_assert = 0;
   int            n_fail   = 0;
   beat_t         exp_q[$];
   logic [W-1:0]  cap[$];
   logic          caperr[$];
   logic [W-1:0]  last_g = '0;
   logic          hist = 1'b0;
   logic [CW-1:0] cnt_m = '0;
   logic          stall_pend = 1'b0;
   logic [W-1:0]  held_d = '0;
   logic          held_m = 1'b0;
   logic [W-1:0]  gv[256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
      logic [W-1:0] r;
      logic         a;
      a = 1'b0;
      r = '0;
      for (int i = W - 1; i >= 0; i--) begin
         a    = a ^ g[i];
         r[i] = a;
      end
      return r;
   endfunction

   task automatic model_push(input logic [W-1:0] d, input logic m);
      beat_t b;
      b.m = m;
      if (m) begin
         b.d = d ^ (d >> 1);
         b.e = 1'b0;
      end else begin
         b.d    = m_g2b(d);
         b.e    = hist && ($countones(d ^ last_g) > 1);
         last_g = d;
         hist   = 1'b1;
      end
      exp_q.push_back(b);
   endtask

   // Drive one cycle's inputs at the falling edge, sample 1 time unit later.
   task automatic step(input logic iv, input logic [W-1:0] id, input logic im,
                       input logic ordy, output logic acc);
      beat_t b;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      in_mode   = im;
      out_ready = ordy;
      #1;
      chk("beat_cnt", beat_cnt, cnt_m);
      if (stall_pend) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, held_d);
         chk("stall_mode", out_mode, held_m);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_beat", exp_q.size(), 1);
         end else begin
            b = exp_q.pop_front();
            chk("out_data", out_data, b.d);
            chk("out_mode", out_mode, b.m);
            chk("out_step_err", out_step_err, b.e);
            cap.push_back(out_data);
            caperr.push_back(out_step_err);
            cnt_m = cnt_m + 1'b1;
         end
      end
      stall_pend = out_valid && !out_ready;
      held_d     = out_data;
      held_m     = out_mode;
      acc        = in_valid && in_ready;
      if (acc) model_push(in_data, in_mode);
   endtask

   task automatic st(input logic iv, input logic [W-1:0] id, input logic im, input logic ordy);
      logic a;
      step(iv, id, im, ordy, a);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         st(1'b0, '0, 1'b0, 1'b1);
         g++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready_low", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_mode", out_mode, 0);
      chk("rst_out_step_err", out_step_err, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_in_ready_high", in_ready, 1);
      exp_q.delete();
      cap.delete();
      caperr.delete();
      hist       = 1'b0;
      last_g     = '0;
      cnt_m      = '0;
      stall_pend = 1'b0;
   endtask

   initial begin
      logic       acc;
      logic       r;
      int         i;
      int         guard;
      logic [7:0] d8;

      // Single G2B beat: latency and value.
      do_reset();
      st(1'b1, 8'hC0, 1'b0, 1'b1);
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_latency_low", out_valid, 0);
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 8'h80);
      chk("t1_out_mode", out_mode, 0);
      chk("t1_step_err", out_step_err, 0);
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_beat_cnt", beat_cnt, 1);
      drain();

      // B2G 0x05 then G2B 0x07, back-to-back.
      do_reset();
      st(1'b1, 8'h05, 1'b1, 1'b1);
      st(1'b1, 8'h07, 1'b0, 1'b1);
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t2_a_data", out_data, 8'h07);
      chk("t2_a_mode", out_mode, 1);
      chk("t2_a_err", out_step_err, 0);
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t2_b_valid", out_valid, 1);
      chk("t2_b_data", out_data, 8'h05);
      chk("t2_b_mode", out_mode, 0);
      chk("t2_b_err", out_step_err, 0);
      drain();

      // Step checker: 00, 01, 03, 00.
      do_reset();
      st(1'b1, 8'h00, 1'b0, 1'b1);
      st(1'b1, 8'h01, 1'b0, 1'b1);
      st(1'b1, 8'h03, 1'b0, 1'b1);
      st(1'b1, 8'h00, 1'b0, 1'b1);
      drain();
      chk("t3_count", cap.size(), 4);
      if (cap.size() == 4) begin
         chk("t3_d0", cap[0], 8'h00);
         chk("t3_d1", cap[1], 8'h01);
         chk("t3_d2", cap[2], 8'h02);
         chk("t3_d3", cap[3], 8'h00);
         chk("t3_e0", caperr[0], 0);
         chk("t3_e1", caperr[1], 0);
         chk("t3_e2", caperr[2], 0);
         chk("t3_e3", caperr[3], 1);
      end

      // 20 beats with random backpressure.
      do_reset();
      i     = 0;
      guard = 0;
      while (i < 20 && guard < 400) begin
         r  = 1'($urandom_range(0, 1));
         d8 = 8'(i * 37);
         step(1'b1, d8, 1'(i & 1), r, acc);
         if (acc) i++;
         guard++;
      end
      chk("t4_accept_timeout", i, 20);
      drain();
      st(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t4_beats", cap.size(), 20);
      chk("t4_beat_cnt", beat_cnt, 20);

      // Exhaustive round trip; beat_cnt wraps after 256.
      do_reset();
      for (int v = 0; v < 256; v++) st(1'b1, 8'(v), 1'b1, 1'b1);
      drain();
      st(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t5_wrap", beat_cnt, 0);
      chk("t5_b2g_count", cap.size(), 256);
      if (cap.size() == 256) begin
         for (int v = 0; v < 256; v++) gv[v] = cap[v];
         cap.delete();
         caperr.delete();
         for (int v = 0; v < 256; v++) st(1'b1, gv[v], 1'b0, 1'b1);
         drain();
         chk("t5_g2b_count", cap.size(), 256);
         if (cap.size() == 256) begin
            for (int v = 0; v < 256; v++) chk("t5_roundtrip", cap[v], v);
         end
      end

      // Reset with both stages full and output stalled.
      do_reset();
      st(1'b1, 8'h00, 1'b0, 1'b0);
      st(1'b1, 8'hFF, 1'b0, 1'b0);
      st(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t6_full_valid", out_valid, 1);
      chk("t6_full_in_ready", in_ready, 0);
      do_reset();
      st(1'b1, 8'h5A, 1'b0, 1'b1);
      drain();
      chk("t6_count", cap.size(), 1);
      if (cap.size() == 1) begin
         chk("t6_data", cap[0], 8'h6C);
         chk("t6_no_err", caperr[0], 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
